vm_change_dispenser: RTL and testbench

//  Change-return engine of the vending machine: converts a change amount (cents) into a stream
//  of denomination codes, largest first (greedy), limited by a per-denomination inventory.

---
 rtl/vm_change_dispenser_if.sv | 49 ++++
 rtl/vm_change_dispenser.sv | 144 ++++++++++++++
 tb/tb_vm_change_dispenser.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vm_change_dispenser_if.sv
// Change-dispenser bus: purchase-controller request/status, coin-ejector
// handshake and customer-deposit notification, bundled for the dispenser core.
interface vm_change_dispenser_if #(
  parameter int AMOUNT_W = 17
) ();

  logic                start_i;
  logic [AMOUNT_W-1:0] change_amount_i;
  logic                busy_o;
  logic                coin_valid_o;
  logic [3:0]          coin_code_o;
  logic                coin_ready_i;
  logic                done_o;
  logic                fail_o;
  logic [AMOUNT_W-1:0] remainder_o;
  logic                deposit_valid_i;
  logic [3:0]          deposit_code_i;

  // Requester / ejector / coin-acceptor side
  modport master (
    output start_i,
    output change_amount_i,
    output coin_ready_i,
    output deposit_valid_i,
    output deposit_code_i,
    input  busy_o,
    input  coin_valid_o,
    input  coin_code_o,
    input  done_o,
    input  fail_o,
    input  remainder_o
  );

  // Dispenser side
  modport slave (
    input  start_i,
    input  change_amount_i,
    input  coin_ready_i,
    input  deposit_valid_i,
    input  deposit_code_i,
    output busy_o,
    output coin_valid_o,
    output coin_code_o,
    output done_o,
    output fail_o,
    output remainder_o
  );

endinterface

// File: rtl/vm_change_dispenser.sv
// Change-return engine: turns a change amount (cents) into a largest-first
// stream of denomination codes, one coin per ejector handshake, bounded by a
// per-denomination coin inventory that customer deposits replenish.
module vm_change_dispenser #(
  parameter int AMOUNT_W = 17,
  parameter int CNT_W    = 8,
  parameter int INIT_CNT = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  vm_change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

  state_t              state;
  logic [AMOUNT_W-1:0] rem;
  logic [3:0]          idx;
  logic [CNT_W-1:0]    cnt [1:15];

  logic [AMOUNT_W-1:0] idx_value;
  logic                idx_avail;
  logic                handshake;

  // Face value in cents of each denomination code (code 0 is not a coin)
  function automatic logic [AMOUNT_W-1:0] coin_value(input logic [3:0] code);
    case (code)
      4'd1:    coin_value = AMOUNT_W'(50000);
      4'd2:    coin_value = AMOUNT_W'(20000);
      4'd3:    coin_value = AMOUNT_W'(10000);
      4'd4:    coin_value = AMOUNT_W'(5000);
      4'd5:    coin_value = AMOUNT_W'(2000);
      4'd6:    coin_value = AMOUNT_W'(1000);
      4'd7:    coin_value = AMOUNT_W'(500);
      4'd8:    coin_value = AMOUNT_W'(200);
      4'd9:    coin_value = AMOUNT_W'(100);
      4'd10:   coin_value = AMOUNT_W'(50);
      4'd11:   coin_value = AMOUNT_W'(25);
      4'd12:   coin_value = AMOUNT_W'(10);
      4'd13:   coin_value = AMOUNT_W'(5);
      4'd14:   coin_value = AMOUNT_W'(2);
      4'd15:   coin_value = AMOUNT_W'(1);
      default: coin_value = '0;
    endcase
  endfunction

  // Value and stock of the denomination currently under scan; idx is kept in
  // 1..15 at all times (reset and start both load 1), so cnt[idx] is in range
  always_comb begin
    idx_value = coin_value(idx);
    idx_avail = (cnt[idx] != '0);
    handshake = (state == EMIT) && bus.coin_ready_i;
  end

  // Dispense sequencer: one denomination examined per SCAN cycle, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rem              <= '0;
      idx              <= 4'd1;
      bus.busy_o       <= 1'b0;
      bus.coin_valid_o <= 1'b0;
      bus.coin_code_o  <= '0;
      bus.done_o       <= 1'b0;
      bus.fail_o       <= 1'b0;
      bus.remainder_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            rem        <= bus.change_amount_i;
            idx        <= 4'd1;
            bus.busy_o <= 1'b1;
            bus.fail_o <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (rem == '0) begin
            bus.done_o      <= 1'b1;
            bus.fail_o      <= 1'b0;
            bus.remainder_o <= rem;
            state           <= DONE;
          end else if ((rem >= idx_value) && idx_avail) begin
            bus.coin_valid_o <= 1'b1;
            bus.coin_code_o  <= idx;
            state            <= EMIT;
          end else if (idx == 4'd15) begin
            bus.done_o      <= 1'b1;
            bus.fail_o      <= 1'b1;
            bus.remainder_o <= rem;
            state           <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        EMIT: begin
          // rem >= idx_value was established in SCAN, so no underflow here;
          // idx is unchanged so the same denomination is retried next
          if (bus.coin_ready_i) begin
            bus.coin_valid_o <= 1'b0;
            bus.coin_code_o  <= '0;
            rem              <= rem - idx_value;
            state            <= SCAN;
          end
        end
        DONE: begin
          bus.done_o <= 1'b0;
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Inventory: deposits add (saturating), handshakes remove; both on one code cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < 16; i++) begin
        cnt[i[3:0]] <= CNT_INIT;
      end
    end else begin
      for (int unsigned i = 1; i < 16; i++) begin
        if (bus.deposit_valid_i && (bus.deposit_code_i == i[3:0])) begin
          if (!(handshake && (idx == i[3:0])) && (cnt[i[3:0]] != CNT_MAX)) begin
            cnt[i[3:0]] <= cnt[i[3:0]] + 1'b1;
          end
        end else if (handshake && (idx == i[3:0])) begin
          cnt[i[3:0]] <= cnt[i[3:0]] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: a greedy reference model pushes
// the expected coin codes to a queue when a request is driven; coins observed
// at the ejector handshake are collected and compared against that queue.
module tb_vm_change_dispenser;

  localparam int AMOUNT_W = 17;
  localparam int CNT_W    = 8;
  localparam int CNT_SAT  = 255;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vm_change_dispenser_if #(.AMOUNT_W(AMOUNT_W)) bus  ();
  vm_change_dispenser_if #(.AMOUNT_W(AMOUNT_W)) bus1 ();

  vm_change_dispenser #(.AMOUNT_W(AMOUNT_W), .CNT_W(CNT_W), .INIT_CNT(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vm_change_dispenser #(.AMOUNT_W(AMOUNT_W), .CNT_W(CNT_W), .INIT_CNT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int compared   = 0;
  int mismatched = 0;

  int exp_q[$];
  int obs_q[$];
  int m_cnt[2][16];
  int coin_val[16] = '{0, 50000, 20000, 10000, 5000, 2000, 1000, 500, 200, 100,
                       50, 25, 10, 5, 2, 1};

  // Collector results
  bit obs_done;
  bit obs_fail;
  int obs_rem;
  int obs_done_cyc;
  int obs_first_cyc;
  int stall_code;
  int stall_bad;
  int code_bad;

  // Greedy reference: pushes expected codes and updates the model inventory
  task automatic model_dispense(input int sel, input int amount, output int rem, output bit fail);
    rem = amount;
    for (int i = 1; i < 16; i++) begin
      while (rem >= coin_val[i] && m_cnt[sel][i] > 0) begin
        rem -= coin_val[i];
        m_cnt[sel][i]--;
        exp_q.push_back(i);
      end
    end
    fail = (rem != 0);
  endtask

  task automatic model_reset();
    for (int i = 1; i < 16; i++) begin
      m_cnt[0][i] = 100;
      m_cnt[1][i] = 1;
    end
  endtask

  // Drives one request on the main DUT and collects coins until done_o (bounded)
  task automatic dispense(input int amount, input int stall, input int dep_code);
    int cyc;
    int stalled;
    obs_q.delete();
    obs_done = 0; obs_fail = 0; obs_rem = -1; obs_done_cyc = -1; obs_first_cyc = -1;
    stall_code = -1; stall_bad = 0; code_bad = 0;
    stalled = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.change_amount_i = AMOUNT_W'(amount);
    bus.coin_ready_i = (stall == 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    cyc = 1;
    while (cyc <= 600 && !obs_done) begin
      bus.deposit_valid_i = 1'b0;
      if (!bus.coin_valid_o && bus.coin_code_o != 4'd0) code_bad++;
      if (bus.coin_valid_o) begin
        if (obs_first_cyc < 0) obs_first_cyc = cyc;
        if (!bus.coin_ready_i) begin
          if (stalled == 0) stall_code = int'(bus.coin_code_o);
          else if (int'(bus.coin_code_o) != stall_code) stall_bad++;
          stalled++;
          if (stalled >= stall) bus.coin_ready_i = 1'b1;
        end
        if (bus.coin_ready_i) begin
          obs_q.push_back(int'(bus.coin_code_o));
          if (dep_code != 0 && int'(bus.coin_code_o) == dep_code) begin
            bus.deposit_valid_i = 1'b1;
            bus.deposit_code_i  = 4'(dep_code);
          end
        end
      end
      if (bus.done_o) begin
        obs_done     = 1;
        obs_fail     = bus.fail_o;
        obs_rem      = int'(bus.remainder_o);
        obs_done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    bus.deposit_valid_i = 1'b0;
    bus.coin_ready_i    = 1'b1;
    compared++;
    if (!obs_done) begin
      mismatched++;
      $display("FAIL dispense_timeout(%0d): done_o not seen within 600 cycles, required within 600", amount);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    compared++; if (bus.busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    compared++; if (bus.coin_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", bus.coin_valid_o); end
    compared++; if (bus.coin_code_o !== 4'd0) begin mismatched++; $display("FAIL reset_code: got %0d want 0", bus.coin_code_o); end
    compared++; if (bus.done_o !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    compared++; if (bus.fail_o !== 1'b0) begin mismatched++; $display("FAIL reset_fail: got %b want 0", bus.fail_o); end
    compared++; if (bus.remainder_o !== '0) begin mismatched++; $display("FAIL reset_rem: got %0d want 0", bus.remainder_o); end
    model_reset();
    for (int i = 1; i < 16; i++) begin
      compared++;
      if (int'(dut.cnt[4'(i)]) != m_cnt[0][i]) begin
        mismatched++;
        $display("FAIL reset_cnt[%0d]: got %0d want %0d", i, dut.cnt[4'(i)], m_cnt[0][i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_greedy_885();
    int er; bit ef; int e; int o;
    model_dispense(0, 885, er, ef);
    dispense(885, 0, 0);
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL g885_count: got %0d coins want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      compared++;
      if (o != e) begin mismatched++; $display("FAIL g885_code: got %0d want %0d", o, e); end
    end
    compared++; if (obs_fail != ef) begin mismatched++; $display("FAIL g885_fail: got %0d want %0d", obs_fail, ef); end
    compared++; if (obs_rem != er) begin mismatched++; $display("FAIL g885_rem: got %0d want %0d", obs_rem, er); end
    compared++; if (obs_first_cyc != 8) begin mismatched++; $display("FAIL g885_first_coin_latency: got %0d want 8", obs_first_cyc); end
    compared++; if (code_bad != 0) begin mismatched++; $display("FAIL g885_code_idle_zero: got %0d bad cycles want 0", code_bad); end
    for (int i = 7; i <= 12; i++) begin
      compared++;
      if (int'(dut.cnt[4'(i)]) != m_cnt[0][i]) begin
        mismatched++;
        $display("FAIL g885_cnt[%0d]: got %0d want %0d", i, dut.cnt[4'(i)], m_cnt[0][i]);
      end
    end
  endtask

  task automatic test_stall_700();
    int er; bit ef; int e; int o;
    model_dispense(0, 700, er, ef);
    dispense(700, 5, 0);
    compared++; if (stall_code != 7) begin mismatched++; $display("FAIL stall_code: got %0d want 7", stall_code); end
    compared++; if (stall_bad != 0) begin mismatched++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL s700_count: got %0d coins want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      compared++;
      if (o != e) begin mismatched++; $display("FAIL s700_code: got %0d want %0d", o, e); end
    end
    compared++; if (obs_rem != er || obs_fail != ef) begin
      mismatched++; $display("FAIL s700_status: got rem %0d fail %0d want rem %0d fail %0d", obs_rem, obs_fail, er, ef);
    end
  endtask

  // Single-coin inventory instance: second request of 3 cents must fail
  task automatic test_inventory_limit();
    int er; bit ef; int e; int o; int cyc; bit done; bit fail; int rem;
    for (int r = 0; r < 2; r++) begin
      model_dispense(1, 3, er, ef);
      obs_q.delete();
      done = 0; fail = 0; rem = -1;
      @(negedge clk);
      bus1.start_i = 1'b1;
      bus1.change_amount_i = AMOUNT_W'(3);
      @(negedge clk);
      bus1.start_i = 1'b0;
      cyc = 1;
      while (cyc <= 100 && !done) begin
        if (bus1.coin_valid_o) obs_q.push_back(int'(bus1.coin_code_o));
        if (bus1.done_o) begin done = 1; fail = bus1.fail_o; rem = int'(bus1.remainder_o); end
        @(negedge clk);
        cyc++;
      end
      compared++; if (!done) begin mismatched++; $display("FAIL inv%0d_timeout: done_o not seen in 100 cycles", r); end
      compared++;
      if (obs_q.size() != exp_q.size()) begin
        mismatched++; $display("FAIL inv%0d_count: got %0d coins want %0d", r, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
        compared++;
        if (o != e) begin mismatched++; $display("FAIL inv%0d_code: got %0d want %0d", r, o, e); end
      end
      compared++; if (fail != ef) begin mismatched++; $display("FAIL inv%0d_fail: got %0d want %0d", r, fail, ef); end
      compared++; if (rem != er) begin mismatched++; $display("FAIL inv%0d_rem: got %0d want %0d", r, rem, er); end
    end
  endtask

  task automatic test_deposit();
    int er; bit ef; int e; int o;
    model_dispense(0, 500, er, ef);
    if (m_cnt[0][7] < CNT_SAT) m_cnt[0][7]++;
    dispense(500, 0, 7);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      compared++;
      if (o != e) begin mismatched++; $display("FAIL dep_code: got %0d want %0d", o, e); end
    end
    compared++;
    if (int'(dut.cnt[4'd7]) != m_cnt[0][7]) begin
      mismatched++; $display("FAIL dep_same_cycle_cnt7: got %0d want %0d", dut.cnt[4'd7], m_cnt[0][7]);
    end
    // Push code 1 past saturation
    for (int n = 0; n < 160; n++) begin
      @(negedge clk);
      bus.deposit_valid_i = 1'b1;
      bus.deposit_code_i  = 4'd1;
      if (m_cnt[0][1] < CNT_SAT) m_cnt[0][1]++;
    end
    @(negedge clk);
    bus.deposit_valid_i = 1'b0;
    compared++;
    if (int'(dut.cnt[4'd1]) != m_cnt[0][1]) begin
      mismatched++; $display("FAIL dep_saturate_cnt1: got %0d want %0d", dut.cnt[4'd1], m_cnt[0][1]);
    end
  endtask

  // Zero amount, with start_i held high through the SCAN and DONE cycles
  task automatic test_zero_and_ignore();
    bit saw_coin;
    saw_coin = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.change_amount_i = '0;
    @(negedge clk);
    bus.change_amount_i = AMOUNT_W'(5);
    compared++; if (bus.busy_o !== 1'b1) begin mismatched++; $display("FAIL zero_busy_c1: got %b want 1", bus.busy_o); end
    compared++; if (bus.done_o !== 1'b0) begin mismatched++; $display("FAIL zero_done_c1: got %b want 0", bus.done_o); end
    @(negedge clk);
    compared++; if (bus.done_o !== 1'b1) begin mismatched++; $display("FAIL zero_done_c2: got %b want 1", bus.done_o); end
    compared++; if (bus.fail_o !== 1'b0) begin mismatched++; $display("FAIL zero_fail: got %b want 0", bus.fail_o); end
    compared++; if (bus.remainder_o !== '0) begin mismatched++; $display("FAIL zero_rem: got %0d want 0", bus.remainder_o); end
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.coin_valid_o || bus.busy_o || bus.done_o) saw_coin = 1;
      @(negedge clk);
    end
    compared++;
    if (saw_coin) begin mismatched++; $display("FAIL busy_start_ignored: got activity after done want idle"); end
  endtask

  task automatic test_reset_midflight();
    int er; bit ef; int e; int o; int w;
    bus.coin_ready_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.change_amount_i = AMOUNT_W'(885);
    @(negedge clk);
    bus.start_i = 1'b0;
    w = 0;
    while (!bus.coin_valid_o && w < 30) begin @(negedge clk); w++; end
    compared++; if (!bus.coin_valid_o) begin mismatched++; $display("FAIL rst_mid_no_coin: got valid 0 want 1"); end
    rst = 1'b1;
    #1;
    compared++; if (bus.coin_valid_o !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid: got %b want 0", bus.coin_valid_o); end
    compared++; if (bus.busy_o !== 1'b0 || bus.coin_code_o !== 4'd0) begin
      mismatched++; $display("FAIL rst_mid_busy_code: got busy %b code %0d want 0 0", bus.busy_o, bus.coin_code_o);
    end
    model_reset();
    for (int i = 1; i < 16; i++) begin
      compared++;
      if (int'(dut.cnt[4'(i)]) != m_cnt[0][i]) begin
        mismatched++; $display("FAIL rst_mid_cnt[%0d]: got %0d want %0d", i, dut.cnt[4'(i)], m_cnt[0][i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.coin_ready_i = 1'b1;
    model_dispense(0, 885, er, ef);
    dispense(885, 0, 0);
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL rst_after_count: got %0d coins want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      compared++;
      if (o != e) begin mismatched++; $display("FAIL rst_after_code: got %0d want %0d", o, e); end
    end
    compared++; if (obs_rem != er || obs_fail != ef) begin
      mismatched++; $display("FAIL rst_after_status: got rem %0d fail %0d want rem %0d fail %0d", obs_rem, obs_fail, er, ef);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;  bus.change_amount_i = '0;  bus.coin_ready_i = 1'b1;
    bus.deposit_valid_i = 1'b0;  bus.deposit_code_i = 4'd0;
    bus1.start_i = 1'b0; bus1.change_amount_i = '0; bus1.coin_ready_i = 1'b1;
    bus1.deposit_valid_i = 1'b0; bus1.deposit_code_i = 4'd0;

    test_reset();
    test_greedy_885();
    test_stall_700();
    test_inventory_limit();
    test_deposit();
    test_zero_and_ignore();
    test_reset_midflight();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
